// File: rtl/mtf_encoder.sv
// Move-to-front encoder placed after bwt_top: one MTF index per accepted char,
// with the table returned to identity at every STRING_LEN-char block boundary.
module mtf_encoder #(
    parameter int STRING_LEN = 32,
    parameter int SYMBOLS    = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       valid_in,
    output logic [7:0] idx_out,
    output logic       valid_out,
    output logic       first_out,
    output logic       last_out,
    output logic       err_out
);

    localparam logic [7:0] LAST_POS = 8'(STRING_LEN - 1);

    logic [7:0] table_q [SYMBOLS];
    logic [7:0] blk_ctr;
    logic       match;
    logic [7:0] match_idx;
    logic       block_end;

    assign block_end = (blk_ctr == LAST_POS);

    // Descending scan so the lowest matching position is the one that sticks.
    // NOTE: both outputs get a default first so the comb block cannot infer a latch.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int j = SYMBOLS - 1; j >= 0; j--) begin
            if (table_q[j] == char_in) begin
                match     = 1'b1;
                match_idx = 8'(j);
            end
        end
    end

    // NOTE: the table is a register file, not a RAM, so it can and must be
    // reset to identity; an SRAM would need a sequenced clear instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < SYMBOLS; j++) table_q[j] <= 8'(j);
            blk_ctr   <= '0;
            idx_out   <= '0;
            valid_out <= 1'b0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            valid_out <= valid_in;
            first_out <= valid_in && (blk_ctr == '0);
            last_out  <= valid_in && block_end;
            err_out   <= valid_in && !match;
            if (valid_in) begin
                idx_out <= match ? match_idx : 8'hFF;
                blk_ctr <= block_end ? '0 : blk_ctr + 8'd1;
                // The block's last char is encoded against the old table, then the table reloads.
                if (block_end) begin
                    for (int j = 0; j < SYMBOLS; j++) table_q[j] <= 8'(j);
                end else if (match) begin
                    table_q[0] <= char_in;
                    for (int j = 1; j < SYMBOLS; j++) begin
                        if (j <= int'(match_idx)) table_q[j] <= table_q[j-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mtf_encoder.sv
// Self-checking bench for mtf_encoder: three instances (32/256, 32/4, 1/256) fed the
// same stream, compared every cycle against a list-based MTF model.
`timescale 1ns/1ps
module tb_mtf_encoder;

    localparam int N = 3;

    typedef struct packed {
        int unsigned      cyc;
        logic [2:0][11:0] o;   // per instance: {valid, first, last, err, idx}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in;
    logic       valid_in;
    logic [7:0] idx_o   [N];
    logic       valid_o [N];
    logic       first_o [N];
    logic       last_o  [N];
    logic       err_o   [N];

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    const int slen [N] = '{32, 32, 1};
    const int syms [N] = '{256, 4, 256};
    logic [7:0] tbl [N][$];
    int         blk [N];
    logic [7:0] last_idx [N];
    exp_t       expq [$];

    mtf_encoder #(.STRING_LEN(32), .SYMBOLS(256)) u_main (
        .clk(clk), .rst(rst), .char_in(char_in), .valid_in(valid_in),
        .idx_out(idx_o[0]), .valid_out(valid_o[0]), .first_out(first_o[0]),
        .last_out(last_o[0]), .err_out(err_o[0]));

    mtf_encoder #(.STRING_LEN(32), .SYMBOLS(4)) u_small (
        .clk(clk), .rst(rst), .char_in(char_in), .valid_in(valid_in),
        .idx_out(idx_o[1]), .valid_out(valid_o[1]), .first_out(first_o[1]),
        .last_out(last_o[1]), .err_out(err_o[1]));

    mtf_encoder #(.STRING_LEN(1), .SYMBOLS(256)) u_len1 (
        .clk(clk), .rst(rst), .char_in(char_in), .valid_in(valid_in),
        .idx_out(idx_o[2]), .valid_out(valid_o[2]), .first_out(first_o[2]),
        .last_out(last_o[2]), .err_out(err_o[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < N; d++) begin
            tbl[d].delete();
            for (int i = 0; i < syms[d]; i++) tbl[d].push_back(8'(i));
            blk[d] = 0;
            last_idx[d] = 8'h00;
        end
    endfunction

    // Plain list MTF: find the symbol, pull it out, put it in front.
    function automatic logic [11:0] model_step(input int d, input logic [7:0] c);
        int pos = -1;
        logic [7:0] idx;
        logic err, first, last;
        for (int i = 0; i < tbl[d].size(); i++)
            if (pos < 0 && tbl[d][i] == c) pos = i;
        if (pos < 0) begin
            idx = 8'hFF;
            err = 1'b1;
        end else begin
            idx = 8'(pos);
            err = 1'b0;
            tbl[d].delete(pos);
            tbl[d].push_front(c);
        end
        first = (blk[d] == 0);
        last  = (blk[d] == slen[d] - 1);
        if (last) begin
            tbl[d].delete();
            for (int i = 0; i < syms[d]; i++) tbl[d].push_back(8'(i));
            blk[d] = 0;
        end else begin
            blk[d]++;
        end
        last_idx[d] = idx;
        return {1'b1, first, last, err, idx};
    endfunction

    task automatic send(input logic [7:0] c, input int e0 = -1, input int e1 = -1, input int e2 = -1);
        exp_t e;
        char_in  = c;
        valid_in = 1'b1;
        e.cyc = cyc + 1;
        for (int d = 0; d < N; d++) e.o[d] = model_step(d, c);
        if (e0 >= 0) check("pin_main_idx", 32'(e.o[0][7:0]), 32'(e0));
        if (e1 >= 0) check("pin_small_idx", 32'(e.o[1][7:0]), 32'(e1));
        if (e2 >= 0) check("pin_len1_idx", 32'(e.o[2][7:0]), 32'(e2));
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exp_t e;
        char_in  = 8'($urandom);
        valid_in = 1'b0;
        e.cyc = cyc + 1;
        for (int d = 0; d < N; d++) e.o[d] = {4'b0000, last_idx[d]};
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        valid_in = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < N; d++)
            check($sformatf("async_reset_outputs_%0d", d),
                  32'({valid_o[d], first_o[d], last_o[d], err_o[d], idx_o[d]}), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        expq.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    check("stale_expectation", expq[0].cyc, cyc);
                    void'(expq.pop_front());
                end
                if (expq.size() > 0 && expq[0].cyc == cyc) begin
                    for (int d = 0; d < N; d++)
                        check($sformatf("model_cmp_dut%0d_cyc%0d", d, cyc),
                              32'({valid_o[d], first_o[d], last_o[d], err_o[d], idx_o[d]}),
                              32'(expq[0].o[d]));
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] rep [5];
        rep = '{8'h62, 8'h62, 8'h61, 8'h62, 8'h61};
        rst = 1'b1;
        valid_in = 1'b0;
        char_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: async reset with live outputs, then first char after release
        send(8'h55, 8'h55);
        do_reset();
        send(8'h61, 8'h61, -1, 8'h61);
        @(negedge clk);
        check("t1_first_out", 32'(first_o[0]), 32'h1);

        // Test 2: back-to-back repeats
        do_reset();
        send(rep[0], 8'h62, -1, 8'h62);
        send(rep[1], 8'h00, -1, 8'h62);
        send(rep[2], 8'h62, -1, 8'h61);
        send(rep[3], 8'h01, -1, 8'h62);
        send(rep[4], 8'h01, -1, 8'h61);

        // Test 3: full block of 0x41, boundary reload
        do_reset();
        send(8'h41, 8'h41);
        for (int i = 1; i < 32; i++) send(8'h41, 8'h00);
        @(negedge clk);
        check("t3_last_out", 32'(last_o[0]), 32'h1);
        send(8'h41, 8'h41);
        @(negedge clk);
        check("t3_first_after_boundary", 32'(first_o[0]), 32'h1);

        // Test 4: same stream with 3-cycle gaps
        do_reset();
        send(rep[0], 8'h62);
        for (int i = 1; i < 5; i++) begin
            repeat (3) idle();
            send(rep[i], (i == 1) ? 8'h00 : (i == 2) ? 8'h62 : 8'h01);
        end

        // Test 5: out-of-range symbol on the 4-entry table
        do_reset();
        send(8'h03, -1, 8'h03);
        send(8'h07, -1, 8'hFF);
        @(negedge clk);
        check("t5_err_out", 32'(err_o[1]), 32'h1);
        send(8'h03, -1, 8'h00);

        // Test 6: reset mid-block, block counter restarts
        do_reset();
        for (int i = 0; i < 10; i++) send(8'($urandom_range(8'h40, 8'h48)));
        do_reset();
        send(8'h62, 8'h62);
        @(negedge clk);
        check("t6_first_after_reset", 32'(first_o[0]), 32'h1);
        for (int i = 1; i < 32; i++) send(8'($urandom_range(8'h60, 8'h66)));
        @(negedge clk);
        check("t6_last_on_32nd", 32'(last_o[0]), 32'h1);

        // Random 4-block stream with gaps
        do_reset();
        for (int i = 0; i < 128; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            if ($urandom_range(0, 7) == 0) send(8'($urandom));
            else send(8'($urandom_range(8'h00, 8'h05)));
        end
        repeat (3) idle();
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
